// File: rtl/ro_measure_ctrl.sv
// ro_measure_ctrl
// Sequencer for a ring-oscillator frequency measurement on the system clock.
// On start: enable the ring, wait SETTLE_CYCLES, count synchronized rising
// edges of the divided ring output over window_len clk cycles, stop the ring
// and hold the result for parallel read or MSB-first serial shift-out.
//
// Ports:
//   clk        system clock, all state on its rising edge
//   reset      synchronous active-high reset
//   start      single-cycle request, accepted in IDLE or DONE
//   window_len measurement window in clk cycles, latched on accepted start
//   ro_div_in  divided ring clock, asynchronous to clk
//   shift      shift-out enable (one bit per cycle), honoured in DONE only
//   ro_ena     registered ring enable
//   busy       registered, high in SETTLE and MEASURE
//   done       registered, high in DONE
//   count      result register, shifts left during readout
//   overflow   registered, set if the counter saturated during MEASURE
//   shift_out  count MSB
module ro_measure_ctrl #(
   parameter int SETTLE_CYCLES = 16,
   parameter int WINDOW_BITS   = 16,
   parameter int COUNT_BITS    = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [WINDOW_BITS-1:0] window_len,
   input  logic                   ro_div_in,
   input  logic                   shift,
   output logic                   ro_ena,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_BITS-1:0]  count,
   output logic                   overflow,
   output logic                   shift_out
);

   // One timer is shared by SETTLE and MEASURE; wide enough for either load.
   localparam int SETTLE_BITS = $clog2(SETTLE_CYCLES) + 1;
   localparam int TW = (WINDOW_BITS > SETTLE_BITS) ? WINDOW_BITS : SETTLE_BITS;
   localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t                 state;
   logic [TW-1:0]          timer;
   logic [WINDOW_BITS-1:0] win_len;
   logic                   s1, s2, s3;
   logic                   ro_edge;

   assign ro_edge   = s2 & ~s3;
   assign shift_out = count[COUNT_BITS-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         timer    <= '0;
         win_len  <= '0;
         s1       <= 1'b0;
         s2       <= 1'b0;
         s3       <= 1'b0;
         ro_ena   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         s1 <= ro_div_in;
         s2 <= s1;
         s3 <= s2;

         case (state)
            ST_IDLE, ST_DONE: begin
               // start takes priority over shift in DONE
               if (start) begin
                  state    <= ST_SETTLE;
                  win_len  <= window_len;
                  count    <= '0;
                  overflow <= 1'b0;
                  timer    <= SETTLE_LOAD;
                  ro_ena   <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
               end else if (state == ST_DONE && shift) begin
                  count <= {count[COUNT_BITS-2:0], 1'b0};
               end
            end

            ST_SETTLE: begin
               if (timer == '0) begin
                  if (win_len == '0) begin
                     state  <= ST_DONE;
                     ro_ena <= 1'b0;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                  end else begin
                     state <= ST_MEASURE;
                     timer <= TW'(win_len);
                  end
               end else begin
                  timer <= timer - TW'(1);
               end
            end

            ST_MEASURE: begin
               if (ro_edge) begin
                  if (count == '1) overflow <= 1'b1;
                  else             count    <= count + COUNT_BITS'(1);
               end
               timer <= timer - TW'(1);
               if (timer == TW'(1)) begin
                  state  <= ST_DONE;
                  ro_ena <= 1'b0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ro_measure_ctrl.sv
module tb_ro_measure_ctrl;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] window_len = '0;
   logic        ro_div_in = 1'b0;
   logic        shift = 1'b0;
   logic        toggle_en = 1'b0;

   logic        ro_ena, busy, done, overflow, shift_out;
   logic [15:0] count;
   logic        ro_ena4, busy4, done4, overflow4, shift_out4;
   logic [3:0]  count4;

   int checks = 0;
   int errors = 0;

   ro_measure_ctrl #(.SETTLE_CYCLES(S), .WINDOW_BITS(16), .COUNT_BITS(16)) dut (
      .clk(clk), .reset(reset), .start(start), .window_len(window_len),
      .ro_div_in(ro_div_in), .shift(shift), .ro_ena(ro_ena), .busy(busy),
      .done(done), .count(count), .overflow(overflow), .shift_out(shift_out)
   );

   ro_measure_ctrl #(.SETTLE_CYCLES(S), .WINDOW_BITS(16), .COUNT_BITS(4)) dut4 (
      .clk(clk), .reset(reset), .start(start), .window_len(window_len),
      .ro_div_in(ro_div_in), .shift(shift), .ro_ena(ro_ena4), .busy(busy4),
      .done(done4), .count(count4), .overflow(overflow4), .shift_out(shift_out4)
   );

   always #5 clk = ~clk;

   // ring stand-in: toggles every clk cycle (period 2 clk)
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (toggle_en) ro_div_in = ~ro_div_in;
      end
   end

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Pulse start with window w; count ro_ena/busy cycles until done rises.
   // poke>0: at that cycle pulse start again with a different window_len.
   task automatic run_meas(input int w, input int poke,
                           output int ena_cyc, output int busy_cyc, output int done_cyc);
      ena_cyc  = 0;
      busy_cyc = 0;
      done_cyc = -1;
      @(posedge clk); #1;
      window_len = 16'(w);
      start = 1'b1;
      @(posedge clk); #1;          // edge 0 sampled start; now in cycle 1
      start = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         if (poke > 0 && k == poke) begin start = 1'b1; window_len = 16'd2; end
         if (poke > 0 && k == poke + 1) start = 1'b0;
         if (ro_ena) ena_cyc++;
         if (busy)   busy_cyc++;
         if (done) begin done_cyc = k; break; end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   typedef struct {
      int w;
      int cnt16;
      int ov16;
      int cnt4;
      int ov4;
      int poke;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int ena_c, busy_c, done_c, seen;
      int exp_bits;

      vecs[0] = '{w: 10, cnt16: 5,  ov16: 0, cnt4: 5,  ov4: 0, poke: 0};
      vecs[1] = '{w: 0,  cnt16: 0,  ov16: 0, cnt4: 0,  ov4: 0, poke: 0};
      vecs[2] = '{w: 2,  cnt16: 1,  ov16: 0, cnt4: 1,  ov4: 0, poke: 0};
      vecs[3] = '{w: 30, cnt16: 15, ov16: 0, cnt4: 15, ov4: 0, poke: 0};
      vecs[4] = '{w: 32, cnt16: 16, ov16: 0, cnt4: 15, ov4: 1, poke: 0};
      vecs[5] = '{w: 40, cnt16: 20, ov16: 0, cnt4: 15, ov4: 1, poke: 0};
      vecs[6] = '{w: 10, cnt16: 5,  ov16: 0, cnt4: 5,  ov4: 0, poke: 7};

      // reset then idle, shift held high to show it is ignored outside DONE
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      shift = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (ro_ena || busy || done || count != 0) seen++;
      end
      shift = 1'b0;
      check("idle_activity", seen, 0);
      check("idle_count", count, 0);
      check("idle_overflow", overflow, 0);
      check("idle_shift_out", shift_out, 0);

      toggle_en = 1'b1;
      repeat (6) @(posedge clk);

      foreach (vecs[i]) begin
         run_meas(vecs[i].w, vecs[i].poke, ena_c, busy_c, done_c);
         check($sformatf("v%0d_ena_cycles", i), ena_c, S + vecs[i].w);
         check($sformatf("v%0d_busy_cycles", i), busy_c, S + vecs[i].w);
         check($sformatf("v%0d_done_cycle", i), done_c, S + vecs[i].w + 1);
         check($sformatf("v%0d_count16", i), count, vecs[i].cnt16);
         check($sformatf("v%0d_ovf16", i), overflow, vecs[i].ov16);
         check($sformatf("v%0d_count4", i), count4, vecs[i].cnt4);
         check($sformatf("v%0d_ovf4", i), overflow4, vecs[i].ov4);
      end

      // serial readout of 0x0005 (last vector result)
      exp_bits = 5;
      shift = 1'b1;
      for (int b = 15; b >= 0; b--) begin
         check($sformatf("shift_bit%0d", b), shift_out, (exp_bits >> b) & 1);
         @(posedge clk); #1;
      end
      shift = 1'b0;
      check("after_shift_count", count, 0);
      check("after_shift_done", done, 1);

      // start and shift together in DONE: start wins
      run_meas(10, 0, ena_c, busy_c, done_c);
      check("pre_collide_count", count, 5);
      start = 1'b1;
      shift = 1'b1;
      window_len = 16'd10;
      @(posedge clk); #1;
      start = 1'b0;
      shift = 1'b0;
      check("collide_busy", busy, 1);
      check("collide_done", done, 0);
      check("collide_count", count, 0);
      done_c = -1;
      for (int k = 2; k <= 100; k++) begin
         @(posedge clk); #1;
         if (done) begin done_c = k; break; end
      end
      check("collide_done_cycle", done_c, S + 10 + 1);
      check("collide_result", count, 5);

      // reset in the middle of MEASURE
      @(posedge clk); #1;
      window_len = 16'd20;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("pre_abort_busy", busy, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_ro_ena", ro_ena, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_count", count, 0);

      run_meas(10, 0, ena_c, busy_c, done_c);
      check("post_abort_done_cycle", done_c, S + 10 + 1);
      check("post_abort_count", count, 5);
      check("post_abort_ovf", overflow, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
